// File: rtl/alu_pkg.sv
// Shared scalar ALU types: divider FSM states and the NZCV flag bundle.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  function automatic alu_flags_t make_flags(input logic q_zero, input logic q_msb,
                                            input logic r_nonzero, input logic ovf);
    return '{z: q_zero, n: q_msb, c: r_nonzero, v: ovf};
  endfunction

endpackage

// File: rtl/alu_adder.sv
// Scalar ALU ripple adder; subtract by feeding ~b with c_in = 1 (c_flag = no borrow).
module alu_adder #(
  parameter int W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_flag
);

  assign {c_flag, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/done handshake and NZCV flags.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
  import alu_pkg::*;
#(
  parameter int N  = 24,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         Z_flag,
  output logic         N_flag,
  output logic         C_flag,
  output logic         V_flag
);

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem, qsh, b_q;
  alu_flags_t    flags;

  logic [N:0]    rem_shift, trial;
  logic          carry, no_borrow;
  logic [N-1:0]  rem_nxt, qsh_nxt;
  logic [N-1:0]  a_load, b_load, res_q, res_r;
  logic          res_v;

  assign rem_shift = {rem, qsh[N-1]};

  alu_adder #(.W(N + 1)) u_trial (
    .a      (rem_shift),
    .b      (~{1'b0, b_q}),
    .c_in   (1'b1),
    .sum    (trial),
    .c_flag (carry)
  );

  // trial[N] is always 0 when carry is set, so this equals carry alone.
  assign no_borrow = carry & ~trial[N];
  assign rem_nxt   = no_borrow ? trial[N-1:0] : rem_shift[N-1:0];
  assign qsh_nxt   = {qsh[N-2:0], no_borrow};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r, ovf;

  function automatic logic [N-1:0] neg(input logic [N-1:0] x);
    return ~x + {{(N-1){1'b0}}, 1'b1};
  endfunction

  assign a_load = A[N-1] ? neg(A) : A;
  assign b_load = B[N-1] ? neg(B) : B;

  always_comb begin
    res_q = neg_q ? neg(qsh_nxt) : qsh_nxt;
    res_r = neg_r ? neg(rem_nxt) : rem_nxt;
    res_v = 1'b0;
    if (ovf) begin
      res_q = {1'b1, {(N-1){1'b0}}};
      res_r = '0;
      res_v = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= A[N-1] ^ B[N-1];
      neg_r <= A[N-1];
      ovf   <= (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
    end
  end
`else
  assign a_load = A;
  assign b_load = B;

  always_comb begin
    res_q = qsh_nxt;
    res_r = rem_nxt;
    res_v = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (B == '0) ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Results are registered on the edge entering DONE so they are valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      qsh   <= '0;
      b_q   <= '0;
      Q     <= '0;
      R     <= '0;
      flags <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          b_q <= b_load;
          if (B == '0) begin
            Q     <= '1;
            R     <= A;
            flags <= make_flags(1'b0, 1'b1, A != '0, 1'b1);
          end else begin
            rem <= '0;
            qsh <= a_load;
            cnt <= CW'(N);
          end
        end
        RUN: begin
          rem <= rem_nxt;
          qsh <= qsh_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Q     <= res_q;
            R     <= res_r;
            flags <= make_flags(res_q == '0, res_q[N-1], res_r != '0, res_v);
          end
        end
        default: ;
      endcase
    end
  end

  assign Z_flag = flags.z;
  assign N_flag = flags.n;
  assign C_flag = flags.c;
  assign V_flag = flags.v;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (N = 24).
module tb_seq_divider;

  localparam int N = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [N-1:0] Q, R;
  logic         busy, done, Z_flag, N_flag, C_flag, V_flag;

  int vectors = 0;
  int miscompares = 0;
  int done_at, busy_n, extra_done;

  seq_divider #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .Q      (Q),
    .R      (R),
    .busy   (busy),
    .done   (done),
    .Z_flag (Z_flag),
    .N_flag (N_flag),
    .C_flag (C_flag),
    .V_flag (V_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts a start, optionally re-pulses start at cycle inj, returns done cycle and busy count.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, input int inj,
                         input logic [N-1:0] ia, input logic [N-1:0] ib,
                         output int d_at, output int b_n);
    d_at = 0;
    b_n  = 0;
    A = a;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    A = 24'h5A5A5A;
    B = 24'h000003;
    for (int i = 1; i <= 40; i++) begin
      if (busy) b_n++;
      if (done) begin
        d_at = i;
        break;
      end
      if (i == inj) begin
        A = ia;
        B = ib;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [N-1:0] q, input logic [N-1:0] r,
                         input logic z, input logic n, input logic c, input logic v);
    chk({tag, ".Q"}, 32'(Q), 32'(q));
    chk({tag, ".R"}, 32'(R), 32'(r));
    chk({tag, ".flags"}, {28'd0, Z_flag, N_flag, C_flag, V_flag}, {28'd0, z, n, c, v});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.Q", 32'(Q), 32'h0);
    chk("rst.R", 32'(R), 32'h0);
    chk("rst.ctl", {30'd0, busy, done}, 32'h0);
    chk("rst.flags", {28'd0, Z_flag, N_flag, C_flag, V_flag}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // 100 / 7
    run_div(24'd100, 24'd7, 0, '0, '0, done_at, busy_n);
    chk("d100_7.done_at", done_at, 25);
    chk("d100_7.busy_n", busy_n, 24);
    chk_res("d100_7", 24'd14, 24'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("d100_7.done_pulse", {31'd0, done}, 32'd0);
    chk("d100_7.hold_Q", 32'(Q), 32'd14);

    // 0xFFFFFF / 1
    run_div(24'hFFFFFF, 24'd1, 0, '0, '0, done_at, busy_n);
    chk("dmax_1.done_at", done_at, 25);
    chk_res("dmax_1", 24'hFFFFFF, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();

    // 5 / 0
    run_div(24'd5, 24'd0, 0, '0, '0, done_at, busy_n);
    chk("d5_0.done_at", done_at, 1);
    chk("d5_0.busy_n", busy_n, 0);
    chk_res("d5_0", 24'hFFFFFF, 24'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    step();

    // 50 / 5 with an ignored second start at cycle 10
    run_div(24'd50, 24'd5, 10, 24'd9, 24'd3, done_at, busy_n);
    chk("d50_5.done_at", done_at, 25);
    chk_res("d50_5", 24'd10, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("d50_5.no_restart", {30'd0, busy, done}, 32'd0);

    // Divisor larger than dividend
    run_div(24'd3, 24'd10, 0, '0, '0, done_at, busy_n);
    chk("d3_10.done_at", done_at, 25);
    chk_res("d3_10", 24'd0, 24'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step();

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div(24'hFFFFF9, 24'd2, 0, '0, '0, done_at, busy_n);
    chk("s_m7_2.done_at", done_at, 25);
    chk_res("s_m7_2", 24'hFFFFFD, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    run_div(24'h800000, 24'hFFFFFF, 0, '0, '0, done_at, busy_n);
    chk("s_ovf.done_at", done_at, 25);
    chk_res("s_ovf", 24'h800000, 24'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
`else
    run_div(24'hFFFFF9, 24'd2, 0, '0, '0, done_at, busy_n);
    chk_res("u_fff9_2", 24'h7FFFFC, 24'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    run_div(24'h800000, 24'hFFFFFF, 0, '0, '0, done_at, busy_n);
    chk_res("u_8000_ffff", 24'h0, 24'h800000, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
`endif

    // Reset in the middle of a run
    A = 24'd50;
    B = 24'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    chk("mid.busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid.Q", 32'(Q), 32'h0);
    chk("mid.R", 32'(R), 32'h0);
    chk("mid.ctl", {30'd0, busy, done}, 32'h0);
    chk("mid.flags", {28'd0, Z_flag, N_flag, C_flag, V_flag}, 32'h0);
    step();
    rst = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) extra_done++;
      step();
    end
    chk("mid.no_done", extra_done, 0);

    run_div(24'd100, 24'd7, 0, '0, '0, done_at, busy_n);
    chk("post_rst.done_at", done_at, 25);
    chk_res("post_rst", 24'd14, 24'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider for the scalar ALU. It is the inverse companion of the ALU add/subtract path.
- Produces quotient, remainder and NZCV-style flags through a start/done handshake.
- One quotient bit per cycle, using a trial subtraction each cycle.
- Sits beside the adder in the scalar ALU. The ALU control holds the operation until done.

Parameters:
- N, 24, operand/quotient/remainder width in bits.
- CW, $clog2(N)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  N  dividend.
- B  input  N  divisor.
- Q  output  N  quotient.
- R  output  N  remainder.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when Q/R/flags become valid.
- Z_flag  output  1  Q == 0.
- N_flag  output  1  Q[N-1].
- C_flag  output  1  remainder nonzero.
- V_flag  output  1  divide-by-zero, or signed overflow when the option is enabled.

Behaviour:
- Reset (async, rst=1): state=IDLE; Q, R, busy, done and all flags = 0; counter = 0. Reset mid-operation abandons the division immediately. No done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k: latch A and B.
  - If B == 0, go to DONE.
  - Otherwise clear the partial remainder, load the quotient shift register with A, set counter = N, and go to RUN.
- RUN, one step per cycle:
  - rem_shift = {rem[N-1:0], qsh[N-1]} (N+1 bits).
  - trial = rem_shift - {1'b0, B}.
  - No borrow: rem = trial[N-1:0] and the new quotient LSB = 1.
  - Borrow: rem = rem_shift[N-1:0] and the new quotient LSB = 0.
  - qsh shifts left with the new bit. Counter decrements; at 1, go to DONE.
- busy = 1 exactly for cycles k+1 .. k+N.
- DONE lasts one cycle: done = 1, and Q/R/flags update in the same cycle, then return to IDLE.
  - Normal division: done at cycle k+N+1.
  - Divide-by-zero: done at cycle k+1, busy never asserts. Result is Q = all ones, R = A, V_flag = 1.
- Q, R and flags hold their last values until the next DONE or reset.
- start while busy or in DONE is ignored. There is no queuing.
- A and B may change after the accepting edge; the latched copies are used.
- Unsigned arithmetic by default. C_flag = (R != 0). V_flag = 0 except for divide-by-zero.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - A and B are two's complement.
  - Magnitudes are latched at start and the unsigned core runs unchanged.
  - In the transition to DONE: Q is negated when sign(A) != sign(B); R takes the sign of A.
  - Overflow case, A = 100..0 and B = all ones: Q = 100..0, R = 0, V_flag = 1.
  - Latency is identical to unsigned.
  - Divide-by-zero response is the same as unsigned, with R = A.
- Undefined: pure unsigned. No sign logic is synthesized.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [1:0] div_state_t {IDLE, RUN, DONE};
  - packed struct alu_flags_t {z, n, c, v}, shared with the rest of the ALU.
- Trial subtraction instantiates the existing scalar ALU adder module at width N+1 with C_in = 1 (subtract mode). Its C_flag = 1 means no borrow.
- No other sub-module.

Test Plan:
- A=100, B=7, start at edge 0 -> busy cycles 1..24, done at 25, Q=14, R=2, Z=0, C=1, V=0.
- A=0xFFFFFF, B=1 -> done at 25, Q=0xFFFFFF, R=0, N=1, C=0.
- A=5, B=0 -> done at cycle 1, busy never high, Q=0xFFFFFF, R=5, V=1.
- Start A=50, B=5, then a second start with A=9, B=3 at cycle 10 -> second start ignored, done at 25 with Q=10, R=0, Z=0.
- rst asserted at cycle 12 of a run -> all outputs 0 immediately, no done pulse. Next start 100/7 completes normally.
- With SEQ_DIVIDER_SIGNED_EN:
  - -7/2 -> Q=0xFFFFFD, R=0xFFFFFF.
  - 0x800000 / 0xFFFFFF -> Q=0x800000, R=0, V=1.
